dmem_ctrl: RTL and testbench
============================

Name: dmem_ctrl

Overview:
- Data-memory access controller downstream of the single-cycle core datapath.
- Takes the ALU result address and store data, runs a req/ack transaction on the external data bus, and returns ReadData to the result mux.
- Supports word and byte (LDRB/STRB) accesses.
- Holds the core with Stall until the access completes, so the memory may have wait states.

Parameters:
- TIMEOUT, 16: maximum REQ-state cycles before the access is abandoned. Legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset. A low level at a rising clk edge resets the block.
- MemRead  input  1  load access requested by the current instruction.
- MemWrite  input  1  store access requested by the current instruction.
- ByteAccess  input  1  1 = byte access, 0 = word access.
- Addr  input  32  byte address, from the ALU result.
- WriteData  input  32  store data, from register file port 2.
- ReadData  output  32  load result to the result mux.
- Stall  output  1  core must hold PC and suppress register/memory writes this cycle.
- MisalignFault  output  1  one-cycle pulse: word access with Addr[1:0] != 0.
- BusError  output  1  one-cycle pulse: access timed out.
- bus_req  output  1  bus request.
- bus_we  output  1  bus write enable.
- bus_addr  output  32  word-aligned address {Addr[31:2], 2'b00}.
- bus_be  output  4  byte enables.
- bus_wdata  output  32  bus write data.
- bus_rdata  input  32  bus read data, valid when bus_ack=1.
- bus_ack  input  1  bus completion. Sampled only while bus_req=1.

Behaviour:
- States: IDLE, REQ, DONE.
- Reset (reset=0 at a clk edge):
  - state=IDLE.
  - bus_req, bus_we, bus_be, bus_addr, bus_wdata = 0.
  - Read-data register = 0, timeout counter = 0, MisalignFault = 0, BusError = 0.
  - Stall follows the IDLE equation.
  - Reset during REQ drops bus_req at that same edge. A late bus_ack afterwards is ignored.
- acc = MemRead|MemWrite. If both are high, the access is treated as a write.
- misaligned = acc & !ByteAccess & (Addr[1:0] != 0).
- IDLE:
  - acc & !misaligned: Stall=1 combinationally in that cycle. At the edge, register bus_we=MemWrite, bus_addr, bus_be, bus_wdata; clear the counter; go to REQ.
  - acc & misaligned: no bus transaction, Stall=0, MisalignFault pulses high for the following cycle. Writes are dropped and ReadData=0.
  - !acc: Stall=0.
- Byte lanes:
  - Word access: bus_be=4'b1111, bus_wdata=WriteData.
  - Byte access: bus_be=1<<Addr[1:0], bus_wdata={4{WriteData[7:0]}}.
- REQ:
  - bus_req=1, Stall=1. Bus outputs are held stable for the whole state.
  - bus_ack=1: capture bus_rdata into the read-data register (reads only), go to DONE.
  - Else the counter increments. When it reaches TIMEOUT-1 without ack: go to DONE, load 0 into the read-data register, and pulse BusError in the DONE cycle.
- DONE:
  - bus_req=0, Stall=0. The core completes the instruction this cycle.
  - Always returns to IDLE. The still-asserted MemRead/MemWrite of the same instruction does not start a new access.
- ReadData is a function of the read-data register and the captured Addr[1:0]/ByteAccess:
  - Word access: the full register.
  - Byte access: the selected byte, zero-extended.
  - 0 whenever no read completed.
- Latency:
  - Zero-wait bus (ack in first REQ cycle): Stall high for 2 cycles, data usable in the 3rd.
  - Each wait state adds 1 cycle.
- Back-to-back accesses: a new access may begin in the IDLE cycle directly after DONE.

Test Plan:
- Word read, zero-wait:
  - Stimulus: reset released, MemRead=1, Addr=0x100, bus_ack in first REQ cycle, bus_rdata=0xDEADBEEF.
  - Required: Stall high for 2 cycles; bus_addr=0x100, bus_be=1111; ReadData=0xDEADBEEF in DONE.
- Byte store, 3 wait states:
  - Stimulus: MemWrite=1, ByteAccess=1, Addr=0x203, WriteData=0x12345678.
  - Required: bus_be=1000, bus_wdata=0x78787878, bus_addr=0x200; Stall high for 5 cycles.
- Byte load:
  - Stimulus: Addr=0x41, bus_rdata=0xAABBCCDD.
  - Required: ReadData=0x000000CC.
- Misaligned word load:
  - Stimulus: Addr=0x102.
  - Required: bus_req never asserted; MisalignFault pulses 1 cycle; Stall=0.
- Timeout:
  - Stimulus: TIMEOUT=4, bus_ack held 0.
  - Required: bus_req high 4 cycles then drops; BusError pulses; ReadData=0; state returns to IDLE.
- Reset mid-REQ:
  - Stimulus: reset=0 during the 2nd REQ cycle, then a late bus_ack.
  - Required: bus_req=0 after that edge; Stall reflects IDLE; the late ack is ignored.

Source files
------------

// File: rtl/dmem_ctrl.sv
// Data-memory access controller: turns core load/store requests into a req/ack bus
// transaction, stalling the core until the access completes or times out.
module dmem_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        ByteAccess,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        MisalignFault,
    output logic        BusError,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  lane_q, lane_d;
    logic        byte_q, byte_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic        mis_q, mis_d;
    logic        berr_q, berr_d;
    logic        acc, misaligned;

    assign acc        = MemRead | MemWrite;
    assign misaligned = acc & ~ByteAccess & (Addr[1:0] != 2'b00);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        lane_d  = lane_q;
        byte_d  = byte_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        mis_d   = 1'b0;
        berr_d  = 1'b0;
        Stall   = 1'b0;
        case (state_q)
            IDLE: begin
                if (acc && !misaligned) begin
                    Stall   = 1'b1;
                    state_d = REQ;
                    we_d    = MemWrite;
                    addr_d  = {Addr[31:2], 2'b00};
                    be_d    = ByteAccess ? (4'b0001 << Addr[1:0]) : 4'b1111;
                    wdata_d = ByteAccess ? {4{WriteData[7:0]}} : WriteData;
                    cnt_d   = 8'd0;
                    lane_d  = Addr[1:0];
                    byte_d  = ByteAccess;
                    rdata_d = 32'd0;
                end else if (misaligned) begin
                    mis_d   = 1'b1;
                    rdata_d = 32'd0;
                end
            end
            REQ: begin
                Stall = 1'b1;
                // An ack on the final allowed cycle still completes the access.
                if (bus_ack) begin
                    if (!we_q) rdata_d = bus_rdata;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = 32'd0;
                    berr_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            rdata_q <= 32'd0;
            lane_q  <= 2'b00;
            byte_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            be_q    <= 4'b0000;
            wdata_q <= 32'd0;
            mis_q   <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            lane_q  <= lane_d;
            byte_q  <= byte_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            mis_q   <= mis_d;
            berr_q  <= berr_d;
        end
    end

    always_comb begin
        ReadData = rdata_q;
        if (byte_q) begin
            case (lane_q)
                2'd0:    ReadData = {24'd0, rdata_q[7:0]};
                2'd1:    ReadData = {24'd0, rdata_q[15:8]};
                2'd2:    ReadData = {24'd0, rdata_q[23:16]};
                default: ReadData = {24'd0, rdata_q[31:24]};
            endcase
        end
    end

    assign bus_req       = (state_q == REQ);
    assign bus_we        = we_q;
    assign bus_addr      = addr_q;
    assign bus_be        = be_q;
    assign bus_wdata     = wdata_q;
    assign MisalignFault = mis_q;
    assign BusError      = berr_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: transaction-level expectations checked every cycle,
// plus literal checks on key results.
module tb_dmem_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite, ByteAccess;
    logic [31:0] Addr, WriteData;
    logic [31:0] ReadData;
    logic        Stall, MisalignFault, BusError;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic        ack_r = 1'b0;
    logic        late_ack = 1'b0;

    assign bus_ack = ack_r | late_ack;

    always #5 clk = ~clk;

    dmem_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .MemRead(MemRead), .MemWrite(MemWrite), .ByteAccess(ByteAccess),
        .Addr(Addr), .WriteData(WriteData), .ReadData(ReadData),
        .Stall(Stall), .MisalignFault(MisalignFault), .BusError(BusError),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    int errors = 0;
    int checks = 0;

    logic        chk_on = 1'b0, chk_bus = 1'b0, chk_rd = 1'b0;
    logic        exp_stall = 1'b0, exp_req = 1'b0, exp_fault = 1'b0, exp_berr = 1'b0, exp_we = 1'b0;
    logic [31:0] exp_addr = '0, exp_wd = '0, exp_rd = '0;
    logic [3:0]  exp_be = '0;

    int          obs_stall, obs_req, obs_fault, obs_berr;
    logic [31:0] obs_rd, obs_addr, obs_wd;
    logic [3:0]  obs_be;
    logic        obs_we;

    int          resp_waits = 0;
    int          resp_cnt = 0;
    logic [31:0] resp_rdata = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] byte_sel(input logic [31:0] w, input logic [1:0] lane);
        logic [31:0] t;
        t = w >> (8 * int'(lane));
        return t & 32'h0000_00FF;
    endfunction

    // Memory model: acks in REQ cycle resp_waits+1; junk data on non-ack cycles.
    initial begin
        bus_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (bus_req) begin
                resp_cnt++;
                ack_r     = (resp_cnt == resp_waits + 1);
                bus_rdata = ack_r ? resp_rdata : 32'hBAD0_BAD0;
            end else begin
                resp_cnt = 0;
                ack_r    = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("Stall", {31'd0, Stall}, {31'd0, exp_stall});
            chk("bus_req", {31'd0, bus_req}, {31'd0, exp_req});
            chk("MisalignFault", {31'd0, MisalignFault}, {31'd0, exp_fault});
            chk("BusError", {31'd0, BusError}, {31'd0, exp_berr});
            if (chk_bus) begin
                chk("bus_addr", bus_addr, exp_addr);
                chk("bus_be", {28'd0, bus_be}, {28'd0, exp_be});
                chk("bus_wdata", bus_wdata, exp_wd);
                chk("bus_we", {31'd0, bus_we}, {31'd0, exp_we});
            end
            if (chk_rd) begin
                chk("ReadData", ReadData, exp_rd);
                obs_rd = ReadData;
            end
            if (Stall) obs_stall++;
            if (MisalignFault) obs_fault++;
            if (BusError) obs_berr++;
            if (bus_req) begin
                obs_req++;
                obs_addr = bus_addr;
                obs_be   = bus_be;
                obs_wd   = bus_wdata;
                obs_we   = bus_we;
            end
        end
    end

    task automatic drive_idle();
        MemRead = 1'b0; MemWrite = 1'b0; ByteAccess = 1'b0; Addr = '0; WriteData = '0;
    endtask

    task automatic clear_obs();
        obs_stall = 0; obs_req = 0; obs_fault = 0; obs_berr = 0;
        obs_rd = '0; obs_addr = '0; obs_wd = '0; obs_be = '0; obs_we = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        drive_idle();
        exp_stall = 1'b0; exp_req = 1'b0; exp_fault = 1'b0; exp_berr = 1'b0;
        chk_bus = 1'b0; chk_rd = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // One instruction's access; waits >= TO means the memory never acks in time.
    task automatic access(input logic rd, input logic wr, input logic byt,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int waits);
        logic mis, tmo, acc;
        int   n_req;
        acc   = rd | wr;
        mis   = acc && !byt && (addr[1:0] != 2'b00);
        tmo   = (waits >= TO);
        n_req = tmo ? TO : waits + 1;
        clear_obs();
        resp_waits = waits;
        resp_rdata = rdata;
        MemRead = rd; MemWrite = wr; ByteAccess = byt; Addr = addr; WriteData = wdata;
        exp_we    = wr;
        exp_addr  = {addr[31:2], 2'b00};
        exp_be    = byt ? (4'b0001 << addr[1:0]) : 4'b1111;
        exp_wd    = byt ? {4{wdata[7:0]}} : wdata;
        exp_stall = acc && !mis;
        exp_req = 1'b0; exp_fault = 1'b0; exp_berr = 1'b0; chk_bus = 1'b0; chk_rd = 1'b0;
        @(posedge clk); #1;
        if (mis) begin
            drive_idle();
            exp_stall = 1'b0; exp_fault = 1'b1; chk_rd = 1'b1; exp_rd = '0;
            @(posedge clk); #1;
            exp_fault = 1'b0; chk_rd = 1'b0;
        end else if (acc) begin
            for (int i = 0; i < n_req; i++) begin
                exp_req = 1'b1; exp_stall = 1'b1; chk_bus = 1'b1;
                @(posedge clk); #1;
            end
            exp_req = 1'b0; exp_stall = 1'b0; chk_bus = 1'b0;
            exp_berr = tmo; chk_rd = 1'b1;
            exp_rd = (wr || tmo) ? 32'd0 : (byt ? byte_sel(rdata, addr[1:0]) : rdata);
            @(posedge clk); #1;
            exp_berr = 1'b0; chk_rd = 1'b0;
            drive_idle();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        drive_idle();
        clear_obs();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        chk_on = 1'b1;
        exp_addr = '0; exp_be = '0; exp_wd = '0; exp_we = 1'b0; exp_rd = '0;
        chk_bus = 1'b1; chk_rd = 1'b1;
        @(posedge clk); #1;
        chk_bus = 1'b0; chk_rd = 1'b0;
        idle_cycles(1);

        access(1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0);
        chk("word read data", obs_rd, 32'hDEAD_BEEF);
        chk("word read stall cycles", obs_stall, 2);
        chk("word read bus_addr", obs_addr, 32'h0000_0100);
        chk("word read bus_be", {28'd0, obs_be}, 32'hF);
        idle_cycles(1);

        access(1'b0, 1'b1, 1'b1, 32'h0000_0203, 32'h1234_5678, 32'h0, 3);
        chk("byte store bus_be", {28'd0, obs_be}, 32'h8);
        chk("byte store bus_wdata", obs_wd, 32'h7878_7878);
        chk("byte store bus_addr", obs_addr, 32'h0000_0200);
        chk("byte store stall cycles", obs_stall, 5);
        chk("byte store bus_we", {31'd0, obs_we}, 32'd1);
        idle_cycles(1);

        access(1'b1, 1'b0, 1'b1, 32'h0000_0041, 32'h0, 32'hAABB_CCDD, 1);
        chk("byte load data", obs_rd, 32'h0000_00CC);

        access(1'b1, 1'b0, 1'b0, 32'h0000_0102, 32'h0, 32'h5555_5555, 0);
        chk("misalign req cycles", obs_req, 0);
        chk("misalign fault cycles", obs_fault, 1);
        chk("misalign stall cycles", obs_stall, 0);
        access(1'b0, 1'b1, 1'b0, 32'h0000_0201, 32'hCAFE_F00D, 32'h0, 0);
        chk("misalign store req cycles", obs_req, 0);
        idle_cycles(1);

        access(1'b1, 1'b0, 1'b0, 32'h0000_0300, 32'h0, 32'h7777_7777, 100);
        chk("timeout req cycles", obs_req, 4);
        chk("timeout berr cycles", obs_berr, 1);
        chk("timeout data", obs_rd, 32'h0);
        access(1'b1, 1'b0, 1'b0, 32'h0000_0304, 32'h0, 32'h6666_6666, TO);
        chk("timeout boundary berr", obs_berr, 1);
        idle_cycles(1);

        access(1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'hA5A5_5A5A, 32'h9999_9999, 0);
        chk("rd+wr treated as write", {31'd0, obs_we}, 32'd1);
        access(1'b1, 1'b0, 1'b0, 32'h0000_0014, 32'h0, 32'h0BAD_F00D, 2);
        chk("back-to-back read data", obs_rd, 32'h0BAD_F00D);
        access(1'b1, 1'b0, 1'b1, 32'h0000_0003, 32'h0, 32'h1122_3344, 0);
        chk("byte lane3 data", obs_rd, 32'h0000_0011);
        access(1'b1, 1'b0, 1'b1, 32'h0000_0080, 32'h0, 32'h1122_3344, 2);
        chk("byte lane0 data", obs_rd, 32'h0000_0044);
        idle_cycles(1);

        // Reset asserted in the second REQ cycle, then a late ack.
        clear_obs();
        resp_waits = 100;
        MemRead = 1'b1; Addr = 32'h0000_0500;
        exp_stall = 1'b1; exp_we = 1'b0; exp_addr = 32'h0000_0500; exp_be = 4'hF; exp_wd = '0;
        @(posedge clk); #1;
        exp_req = 1'b1; chk_bus = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        drive_idle();
        late_ack = 1'b1;
        exp_req = 1'b0; exp_stall = 1'b0;
        exp_addr = '0; exp_be = '0; exp_wd = '0; exp_we = 1'b0;
        chk_rd = 1'b1; exp_rd = '0;
        repeat (2) begin @(posedge clk); #1; end
        late_ack = 1'b0;
        chk("reset mid-REQ req cycles", obs_req, 2);
        idle_cycles(1);

        access(1'b1, 1'b0, 1'b0, 32'h0000_0600, 32'h0, 32'h1357_9BDF, 1);
        chk("post-reset read data", obs_rd, 32'h1357_9BDF);
        idle_cycles(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
